// File: rtl/fxp_requant_stream.sv
// fxp_requant_stream: two-stage streaming requantizer (round-half-up, then saturate) with overflow stats.
// Revision: 1.0
`default_nettype none

module fxp_requant_stream #(
  parameter int DIN_WIDTH  = 32,
  parameter int DIN_FRAC   = 30,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_FRAC  = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DIN_WIDTH-1:0]  s_data,
  input  logic                  s_ovr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DOUT_WIDTH-1:0] m_data,
  output logic                  m_ovr,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  ovr_count,
  output logic                  ovr_sticky
);

  localparam int SH = DIN_FRAC - DOUT_FRAC;
  localparam int RW = DIN_WIDTH + 1 - SH;
  localparam logic [DOUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  if (DOUT_FRAC > DIN_FRAC) begin : g_param_check
    $error("fxp_requant_stream: DOUT_FRAC must not exceed DIN_FRAC");
  end

  logic                  en;
  logic [DIN_WIDTH:0]    ext;
  logic [RW-1:0]         round_r;
  logic                  sat;
  logic [DOUT_WIDTH-1:0] sat_data;

  logic                  s1_valid_q, s1_valid_d;
  logic [RW-1:0]         s1_r_q, s1_r_d;
  logic                  s1_ovr_q, s1_ovr_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DOUT_WIDTH-1:0] s2_data_q, s2_data_d;
  logic                  s2_ovr_q, s2_ovr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sticky_q, sticky_d;
  logic                  ovr_xfer;

  assign en  = !s2_valid_q || m_ready;
  assign ext = {s_data[DIN_WIDTH-1], s_data};

  // One extra bit of headroom keeps the rounding carry of the most positive input.
  if (SH > 0) begin : g_round
    localparam logic [DIN_WIDTH:0] HALF = {{DIN_WIDTH{1'b0}}, 1'b1} << (SH - 1);
    logic [DIN_WIDTH:0] sum;
    assign sum     = ext + HALF;
    assign round_r = RW'(sum >> SH);
  end else begin : g_no_round
    assign round_r = ext;
  end

  if (RW > DOUT_WIDTH) begin : g_sat
    logic [RW-DOUT_WIDTH:0] hi;
    assign hi       = s1_r_q[RW-1:DOUT_WIDTH-1];
    assign sat      = !((&hi) || !(|hi));
    assign sat_data = !sat ? s1_r_q[DOUT_WIDTH-1:0] : (s1_r_q[RW-1] ? SAT_MIN : SAT_MAX);
  end else if (RW == DOUT_WIDTH) begin : g_exact
    assign sat      = 1'b0;
    assign sat_data = s1_r_q;
  end else begin : g_extend
    assign sat      = 1'b0;
    assign sat_data = {{(DOUT_WIDTH-RW){s1_r_q[RW-1]}}, s1_r_q};
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_r_d     = s1_r_q;
    s1_ovr_d   = s1_ovr_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ovr_d   = s2_ovr_q;
    if (en) begin
      s1_valid_d = s_valid;
      s1_r_d     = round_r;
      s1_ovr_d   = s_ovr;
      s2_valid_d = s1_valid_q;
      s2_data_d  = sat_data;
      s2_ovr_d   = s1_ovr_q | sat;
    end
  end

  // A clear and a counted transfer in the same cycle leave the counter at one.
  assign ovr_xfer = s2_valid_q && m_ready && s2_ovr_q;

  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr_stats) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (ovr_xfer) begin
      sticky_d = 1'b1;
      if (cnt_d != '1) begin
        cnt_d = cnt_d + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
      s1_ovr_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovr_q   <= 1'b0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_r_q     <= s1_r_d;
      s1_ovr_q   <= s1_ovr_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovr_q   <= s2_ovr_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign s_ready    = en;
  assign m_valid    = s2_valid_q;
  assign m_data     = s2_data_q;
  assign m_ovr      = s2_ovr_q;
  assign ovr_count  = cnt_q;
  assign ovr_sticky = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_fxp_requant_stream.sv
// tb_fxp_requant_stream: scoreboard bench for fxp_requant_stream (default formats, 4-bit counter).
// Revision: 1.0
`default_nettype none

module tb_fxp_requant_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_ovr = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_ovr;
  logic        clr_stats = 1'b0;
  logic [3:0]  ovr_count;
  logic        ovr_sticky;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          t;
  } exp_t;

  exp_t sbq[$];

  fxp_requant_stream #(
    .DIN_WIDTH (32),
    .DIN_FRAC  (30),
    .DOUT_WIDTH(16),
    .DOUT_FRAC (15),
    .CNT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_ovr     (s_ovr),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_ovr     (m_ovr),
    .clr_stats (clr_stats),
    .ovr_count (ovr_count),
    .ovr_sticky(ovr_sticky)
  );

  always #5 clk = ~clk;

  // Reference: Q1.30 -> Q0.15 with round-half-up and clamp, in plain integer arithmetic.
  function automatic exp_t model(input logic [31:0] d, input logic ov);
    exp_t   e;
    longint x;
    longint r;
    logic   sat;
    x   = longint'($signed(d));
    r   = (x + 64'sd16384) >>> 15;
    sat = 1'b0;
    if (r > 32767) begin
      e.d = 16'h7FFF; sat = 1'b1;
    end else if (r < -32768) begin
      e.d = 16'h8000; sat = 1'b1;
    end else begin
      e.d = r[15:0];
    end
    e.o = ov | sat;
    e.t = 0;
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] d, input logic ov, input logic mr,
                       input logic clr, output logic acc, output logic got,
                       output logic [15:0] gd, output logic go);
    exp_t e;
    @(negedge clk);
    s_valid = v; s_data = d; s_ovr = ov; m_ready = mr; clr_stats = clr;
    #1;
    cyc++;
    acc = s_valid && s_ready;
    got = m_valid && m_ready;
    gd  = m_data;
    go  = m_ovr;
    if (acc) begin
      e = model(d, ov);
      e.t = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    n_checks++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL reset_m_data got=%h exp=0000", m_data); end
    n_checks++; if (m_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_m_ovr got=%b exp=0", m_ovr); end
    n_checks++; if (ovr_count !== 4'h0) begin n_fail++; $display("FAIL reset_ovr_count got=%0d exp=0", ovr_count); end
    n_checks++; if (ovr_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovr_sticky got=%b exp=0", ovr_sticky); end
    rst = 1'b0;
  endtask

  task automatic test_round_sat();
    logic [31:0] vin  [8];
    logic        vov  [8];
    logic [15:0] vexp [8];
    logic        vexo [8];
    logic acc, got, go;
    logic [15:0] gd;
    exp_t e;
    int outn = 0;
    vin  = '{32'h2000_0000, 32'h0000_4000, 32'hFFFF_C000, 32'h0000_3FFF,
             32'h3FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000};
    vov  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vexp = '{16'h4000, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000};
    vexo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 30 && outn < 8; k++) begin
      cycle(k < 8, (k < 8) ? vin[k] : 32'h0, (k < 8) ? vov[k] : 1'b0, 1'b1, 1'b0, acc, got, gd, go);
      if (got) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rs_spurious_output got=%h", gd);
        end else begin
          e = sbq.pop_front();
          n_checks++; if (gd !== vexp[outn]) begin n_fail++; $display("FAIL rs_data[%0d] got=%h exp=%h", outn, gd, vexp[outn]); end
          n_checks++; if (go !== vexo[outn]) begin n_fail++; $display("FAIL rs_ovr[%0d] got=%b exp=%b", outn, go, vexo[outn]); end
          n_checks++; if (gd !== e.d || go !== e.o) begin n_fail++; $display("FAIL rs_model[%0d] got=%h/%b exp=%h/%b", outn, gd, go, e.d, e.o); end
          n_checks++; if (cyc - e.t !== 2) begin n_fail++; $display("FAIL rs_latency[%0d] got=%0d exp=2", outn, cyc - e.t); end
          outn++;
        end
      end
    end
    n_checks++; if (outn !== 8) begin n_fail++; $display("FAIL rs_count got=%0d exp=8", outn); end
  endtask

  task automatic test_backpressure();
    logic acc, got, go, mr, prev_stall;
    logic [15:0] gd, prev_d;
    logic [31:0] din;
    exp_t e;
    int idx = 0;
    int outn = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    for (int k = 0; k < 100 && outn < 8; k++) begin
      mr  = (k % 4 == 0) || (k % 4 == 3);
      din = 32'(idx + 1) << 15;
      cycle(idx < 8, din, 1'b0, mr, 1'b0, acc, got, gd, go);
      n_checks++; if (s_ready !== !(m_valid && !m_ready)) begin n_fail++; $display("FAIL bp_s_ready cyc=%0d got=%b m_valid=%b m_ready=%b", k, s_ready, m_valid, m_ready); end
      if (prev_stall) begin
        n_checks++; if (m_valid !== 1'b1 || m_data !== prev_d) begin n_fail++; $display("FAIL bp_stable cyc=%0d got=%b/%h exp=1/%h", k, m_valid, m_data, prev_d); end
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      if (acc) idx++;
      if (got) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL bp_spurious_output got=%h", gd);
        end else begin
          e = sbq.pop_front();
          n_checks++; if (gd !== 16'(outn + 1) || gd !== e.d) begin n_fail++; $display("FAIL bp_order[%0d] got=%h exp=%h", outn, gd, 16'(outn + 1)); end
          outn++;
        end
      end
    end
    n_checks++; if (outn !== 8 || sbq.size() !== 0) begin n_fail++; $display("FAIL bp_count got=%0d left=%0d exp=8/0", outn, sbq.size()); end
  endtask

  task automatic test_random();
    logic acc, got, go;
    logic [15:0] gd;
    exp_t e;
    int sent = 0;
    int outn = 0;
    for (int k = 0; k < 200 && outn < 30; k++) begin
      cycle(sent < 30, $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, acc, got, gd, go);
      if (acc) sent++;
      if (got) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL rnd_spurious_output got=%h", gd);
        end else begin
          e = sbq.pop_front();
          n_checks++; if (gd !== e.d || go !== e.o) begin n_fail++; $display("FAIL rnd[%0d] got=%h/%b exp=%h/%b", outn, gd, go, e.d, e.o); end
          outn++;
        end
      end
    end
    n_checks++; if (outn !== 30) begin n_fail++; $display("FAIL rnd_count got=%0d exp=30", outn); end
  endtask

  task automatic test_counter();
    logic acc, got, go;
    logic [15:0] gd;
    exp_t e;
    int outn = 0;
    logic seen;
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, acc, got, gd, go);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc, got, gd, go);
    n_checks++; if (ovr_count !== 4'd0 || ovr_sticky !== 1'b0) begin n_fail++; $display("FAIL cnt_clear got=%0d/%b exp=0/0", ovr_count, ovr_sticky); end
    // Stalled overflowing output must not count.
    cycle(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, acc, got, gd, go);
    repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc, got, gd, go);
    n_checks++; if (m_valid !== 1'b1 || m_ovr !== 1'b1 || ovr_count !== 4'd0 || ovr_sticky !== 1'b0) begin
      n_fail++; $display("FAIL cnt_stall got=v%b o%b c%0d s%b exp=v1 o1 c0 s0", m_valid, m_ovr, ovr_count, ovr_sticky);
    end
    for (int k = 0; k < 60 && outn < 20; k++) begin
      cycle(k < 19, 32'h0, 1'b1, 1'b1, 1'b0, acc, got, gd, go);
      if (got) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL cnt_spurious_output got=%h", gd);
        end else begin
          e = sbq.pop_front();
          n_checks++; if (go !== 1'b1 || gd !== e.d) begin n_fail++; $display("FAIL cnt_ovr[%0d] got=%h/%b exp=%h/1", outn, gd, go, e.d); end
          outn++;
        end
      end
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc, got, gd, go);
    n_checks++; if (ovr_count !== 4'd15 || ovr_sticky !== 1'b1) begin n_fail++; $display("FAIL cnt_saturate got=%0d/%b exp=15/1", ovr_count, ovr_sticky); end
    // Clear lands in the same cycle as the 21st overflow transfer.
    seen = 1'b0;
    cycle(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, acc, got, gd, go);
    for (int k = 0; k < 6 && !seen; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc, got, gd, go);
      if (got) begin
        seen = 1'b1;
        clr_stats = 1'b1;
        if (sbq.size() != 0) e = sbq.pop_front();
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL cnt_clr_xfer_timeout got=0 exp=1"); end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc, got, gd, go);
    n_checks++; if (ovr_count !== 4'd1 || ovr_sticky !== 1'b1) begin n_fail++; $display("FAIL cnt_clr_with_xfer got=%0d/%b exp=1/1", ovr_count, ovr_sticky); end
  endtask

  task automatic test_reset_midstream();
    logic acc, got, go;
    logic [15:0] gd;
    cycle(1'b1, 32'h0002_8000, 1'b1, 1'b0, 1'b0, acc, got, gd, go);
    cycle(1'b1, 32'h0003_0000, 1'b1, 1'b0, 1'b0, acc, got, gd, go);
    cycle(1'b1, 32'h0003_8000, 1'b0, 1'b0, 1'b0, acc, got, gd, go);
    n_checks++; if (m_valid !== 1'b1 || s_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full got=v%b r%b exp=v1 r0", m_valid, s_ready); end
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (m_valid !== 1'b0 || s_ready !== 1'b1 || ovr_count !== 4'd0 || ovr_sticky !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got=v%b r%b c%0d s%b exp=v0 r1 c0 s0", m_valid, s_ready, ovr_count, ovr_sticky);
    end
    sbq.delete();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc, got, gd, go);
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale cyc=%0d got=%b/%h exp=0", k, m_valid, gd); end
    end
  endtask

  initial begin
    test_reset();
    test_round_sat();
    test_backpressure();
    test_random();
    test_counter();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/fxp_requant_stream.md
Name: fxp_requant_stream

Overview:
Streaming signed fixed-point requantizer with a valid/ready handshake. It reduces wide filter datapath results, such as accumulator outputs, to a narrower output format using round-half-up and saturation. It consumes the upstream overflow flag that travels alongside each sample, merges it with its own saturation events, and keeps an overflow event count and a sticky flag for software. It sits between the filter accumulator and the output or coefficient-update stage.

Parameters:
DIN_WIDTH, 32, input word width in bits, signed two's complement
DIN_FRAC, 30, input fractional bits
DOUT_WIDTH, 16, output word width in bits, signed two's complement
DOUT_FRAC, 15, output fractional bits; must satisfy DOUT_FRAC <= DIN_FRAC (elaboration error otherwise)
CNT_WIDTH, 16, overflow event counter width

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous reset, active-high
s_valid  in  1  input sample valid
s_ready  out  1  block can accept an input sample
s_data  in  DIN_WIDTH  input sample
s_ovr  in  1  upstream overflow flag for this sample
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts the output sample
m_data  out  DOUT_WIDTH  requantized sample
m_ovr  out  1  overflow flag for this sample (upstream OR local)
clr_stats  in  1  clears ovr_count and ovr_sticky
ovr_count  out  CNT_WIDTH  number of output transfers with m_ovr=1; saturates at all-ones
ovr_sticky  out  1  set on the first output transfer with m_ovr=1

Behaviour:
- Reset: s_ready=1, m_valid=0, m_data=0, m_ovr=0, ovr_count=0, ovr_sticky=0. Both pipeline stages are emptied. A reset during a stall discards any in-flight samples.
- Pipeline:
  - Two register stages: S1 = round, S2 = saturate. Latency is 2 cycles from the input transfer to m_valid, provided there is no stall.
  - Global advance enable is en = !m_valid || m_ready. s_ready = en.
  - An input transfer occurs when s_valid && s_ready. An output transfer occurs when m_valid && m_ready.
  - When en=0, every stage holds its data, valid bit and ovr bit.
  - Bubbles propagate as invalid stages. Throughput is 1 sample per clock while m_ready stays high.
- Rounding (S1):
  - SH = DIN_FRAC - DOUT_FRAC.
  - If SH>0, r = (s_data sign-extended to DIN_WIDTH+1 bits) + 2^(SH-1), then arithmetic shift right by SH. Ties round toward +infinity.
  - If SH=0, r = s_data sign-extended; no rounding.
  - S1 stores r at width DIN_WIDTH+1-SH so that the rounding carry is never lost, together with s_ovr.
- Saturation (S2):
  - Output integer bits: IO = DOUT_WIDTH - DOUT_FRAC.
  - The allowed range is [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1] in output LSBs.
  - If r is above the range, m_data = 0x7FF..F. If r is below the range, m_data = 0x800..0. In either case sat=1.
  - Otherwise m_data = the low DOUT_WIDTH bits of r and sat=0.
  - If the input has fewer integer bits than the output, r sign-extends and sat is always 0.
  - m_ovr = stored s_ovr OR sat.
- Statistics:
  - On each output transfer with m_ovr=1, ovr_count increments and holds at 2^CNT_WIDTH-1; ovr_sticky is set to 1.
  - clr_stats=1 clears both. If a qualifying transfer happens in the same cycle, ovr_count=1 and ovr_sticky=1 after the edge.
  - Non-transferred cycles, including stalls with m_valid=1 and m_ovr=1, never count.
- m_data and m_ovr must remain stable while m_valid=1 and m_ready=0.

Test Plan:
- Defaults, m_ready=1, s_data=0x2000_0000, s_ovr=0 -> 2 cycles later m_data=0x4000, m_ovr=0.
- Rounding: s_data=0x0000_4000 -> m_data=0x0001. s_data=0xFFFF_C000 -> m_data=0x0000. s_data=0x0000_3FFF -> m_data=0x0000.
- Saturation:
  - s_data=0x3FFF_FFFF -> m_data=0x7FFF, m_ovr=1.
  - s_data=0x8000_0000 -> m_data=0x8000, m_ovr=1.
  - s_data=0xC000_0000 -> m_data=0x8000, m_ovr=0.
  - s_data=0, s_ovr=1 -> m_data=0, m_ovr=1.
- Backpressure: 8 consecutive samples 1..8 (<<15) with m_ready toggling 1,0,0,1,... -> outputs 1..8 in order, none lost or duplicated, m_data stable while stalled, s_ready=0 exactly when m_valid=1 and m_ready=0.
- Counter: CNT_WIDTH=4, 20 overflowing transfers -> ovr_count=15, ovr_sticky=1. Then clr_stats coinciding with a 21st overflow transfer -> ovr_count=1.
- Reset mid-stream: assert rst with both stages full and m_ready=0 -> the next cycle shows m_valid=0, s_ready=1, ovr_count=0, and no stale sample ever appears.
